ex_alu_seq: RTL and testbench
=============================

Name: ex_alu_seq

Overview:
- Execute-stage consumer at the far end of the ID/EX pipeline register; drains decoded instructions from it with a valid/ready handshake.
- Computes RV32I integer results and presents one writeback beat per instruction to the register file.
- Non-shift ops complete in one cycle. Shifts run on an iterative 1-bit-per-cycle shifter, stalling ID/EX through in_ready while busy.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- SHAMT_W, 5, shift-amount width (log2 XLEN)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush_i  input  1  synchronous kill of in-flight and offered instruction
- in_valid_i  input  1  ID/EX register holds a valid instruction
- in_ready_o  output  1  block accepts the instruction this cycle
- opcode_i  input  7  decoded opcode
- rd_i  input  5  destination register address
- funct3_i  input  3  decoded funct3
- funct7_i  input  7  decoded funct7 (I-type shifts: imm[11:5])
- imm_i  input  32  sign-extended immediate
- rs1_data_i  input  32  rs1 operand value
- rs2_data_i  input  32  rs2 operand value
- wb_valid_o  output  1  one-cycle writeback pulse
- wb_we_o  output  1  register-file write enable, qualified by wb_valid_o
- wb_rd_o  output  5  writeback address
- wb_data_o  output  32  writeback data
- illegal_o  output  1  one-cycle pulse, accepted opcode unsupported
- busy_o  output  1  iterative shift in progress

Behaviour:
- Reset: FSM=IDLE; wb_valid_o, wb_we_o, illegal_o, busy_o = 0; wb_rd_o=0; wb_data_o=0; shift counter/accumulator=0. in_ready_o=1 from the first cycle after reset.
- Accept = in_valid_i & in_ready_o & ~flush_i, sampled at the rising edge.
- in_ready_o = (state==IDLE). Purely combinational from state; it never depends on in_valid_i.
- Supported opcodes:
  - OP 0110011: operand B = rs2_data_i.
  - OP-IMM 0010011: operand B = imm_i.
  - LUI 0110111: result = imm_i.
- funct3 decoding:
  - 000: ADD; SUB only when OP and funct7[5]=1.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR. 110: OR. 111: AND.
  - 001: SLL.
  - 101: SRL, or SRA when funct7[5]=1.
- shamt = OP ? rs2_data_i[4:0] : imm_i[4:0].
- Arithmetic is modulo 2^32 with no overflow flag. SLT/SLTU produce 32'h0 or 32'h1.
- Unsupported opcode accepted: wb_valid_o=1, wb_we_o=0, illegal_o=1, wb_data_o=0, one cycle after accept.
- FSM states: IDLE and SHIFT.
  - IDLE, accept of a non-shift op or a shift with shamt=0: registered result appears with wb_valid_o=1 on the next cycle (latency 1); state stays IDLE. Back-to-back accepts give back-to-back wb pulses.
  - IDLE, accept of a shift with shamt=N>0: load acc=rs1_data_i, cnt=N, latch rd and shift type; go to SHIFT; busy_o=1.
  - SHIFT: each edge acc shifts 1 bit (SRA replicates bit 31) and cnt decrements. On the edge where cnt becomes 0: wb_data_o=result, wb_valid_o=1, state returns to IDLE.
  - Shift latency is N cycles from accept to wb_valid_o; in_ready_o is low for N cycles. A new instruction can be accepted on the same edge that raises the shift's wb_valid_o.
- wb_we_o = wb_valid_o & (rd != 0) & supported. An rd=x0 write still pulses wb_valid_o with wb_we_o=0.
- wb_valid_o, wb_we_o and illegal_o are single-cycle pulses; they are 0 in any cycle without a completion. wb_rd_o and wb_data_o hold their last value between pulses.
- No writeback backpressure: the register file always accepts.
- flush_i (priority below rst, above everything else):
  - In SHIFT: return to IDLE; no wb_valid_o for the killed shift.
  - With in_valid_i in IDLE: the instruction is not accepted.
  - A completion registered on the same edge as flush_i is suppressed.
- rst asserted mid-shift: identical to the reset state next cycle; no writeback.

Test Plan:
- ADD x3, rs1=0x7FFFFFFF, rs2=1 → next cycle wb_valid=1, we=1, rd=3, data=0x80000000. Same op with funct7=0x20 (SUB) and rs1=0, rs2=1 → data=0xFFFFFFFF.
- SRAI x5, rs1=0x80000000, imm=0x41F (shamt 31, funct7=0x20) → in_ready low 31 cycles; wb_valid exactly 31 cycles after accept; data=0xFFFFFFFF. SLL with rs2[4:0]=0 → latency 1, data=rs1.
- Back-to-back: ADDI x1,x0,5; ORI x2,x0,3; LUI x4,0x12345000 offered on consecutive cycles → three consecutive wb pulses, data 5, 3, 0x12345000.
- SRLI shamt=8 accepted, flush_i asserted on cycle 4 → no wb_valid; in_ready=1 next cycle. The following ADD completes normally.
- Opcode 0000011 (load) → wb_valid=1, we=0, illegal=1 for one cycle. ADDI to rd=0 → wb_valid=1, we=0, illegal=0.
- rst asserted during SHIFT (shamt=20, cycle 10) → next cycle all outputs 0, in_ready=1; no wb_valid ever appears for that shift.

Source files
------------

// File: rtl/ex_alu_seq.sv
// Execute-stage ALU for RV32I integer ops. Single-cycle results for
// everything except shifts; shifts use a 1-bit-per-cycle iterative
// shifter and stall the ID/EX register through in_ready_o.
module ex_alu_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [6:0]         opcode_i,
  input  logic [4:0]         rd_i,
  input  logic [2:0]         funct3_i,
  input  logic [6:0]         funct7_i,
  input  logic [XLEN-1:0]    imm_i,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  output logic               wb_valid_o,
  output logic               wb_we_o,
  output logic [4:0]         wb_rd_o,
  output logic [XLEN-1:0]    wb_data_o,
  output logic               illegal_o,
  output logic               busy_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_reg;
  logic [XLEN-1:0]      acc_reg;
  logic [SHAMT_W-1:0]   cnt_reg;
  logic [4:0]           sh_rd_reg;
  logic                 sh_left_reg;
  logic                 sh_arith_reg;
  logic                 wb_valid_reg;
  logic                 wb_we_reg;
  logic [4:0]           wb_rd_reg;
  logic [XLEN-1:0]      wb_data_reg;
  logic                 illegal_reg;
  logic                 busy_reg;

  logic                 is_op;
  logic                 is_op_imm;
  logic                 is_lui;
  logic                 supported;
  logic                 is_shift;
  logic                 accept;
  logic [XLEN-1:0]      op_b;
  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      alu_result;
  logic [XLEN-1:0]      shl_next;
  logic [XLEN-1:0]      shr_next;
  logic [XLEN-1:0]      shift_next;

  // Only funct7[5] selects SUB/SRA; the rest of the field is don't-care.
  logic unused_funct7;
  assign unused_funct7 = &{1'b0, funct7_i[6], funct7_i[4:0]};

  assign in_ready_o = (state_reg == IDLE);
  assign accept     = in_valid_i & in_ready_o & ~flush_i;

  assign is_op     = (opcode_i == OPC_OP);
  assign is_op_imm = (opcode_i == OPC_OP_IMM);
  assign is_lui    = (opcode_i == OPC_LUI);
  assign supported = is_op | is_op_imm | is_lui;
  assign is_shift  = (is_op | is_op_imm) & (funct3_i[1:0] == 2'b01);

  // OP uses rs2 for both operand B and the shift amount; OP-IMM uses imm.
  assign op_b  = is_op ? rs2_data_i : imm_i;
  assign shamt = op_b[SHAMT_W-1:0];

  // Single-cycle result; shifts that reach here have shamt=0 and return rs1.
  always_comb begin
    alu_result = rs1_data_i;
    case (funct3_i)
      3'b000:  alu_result = (is_op & funct7_i[5]) ? rs1_data_i - op_b
                                                  : rs1_data_i + op_b;
      3'b010:  alu_result = {{(XLEN-1){1'b0}}, $signed(rs1_data_i) < $signed(op_b)};
      3'b011:  alu_result = {{(XLEN-1){1'b0}}, rs1_data_i < op_b};
      3'b100:  alu_result = rs1_data_i ^ op_b;
      3'b110:  alu_result = rs1_data_i | op_b;
      3'b111:  alu_result = rs1_data_i & op_b;
      default: alu_result = rs1_data_i;
    endcase
    if (is_lui) alu_result = imm_i;
  end

  // One-bit shift step of the accumulator, built per bit.
  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_shift_bit
      if (gi == 0) begin : g_lsb
        assign shl_next[gi] = 1'b0;
      end else begin : g_lsb_n
        assign shl_next[gi] = acc_reg[gi-1];
      end
      if (gi == XLEN-1) begin : g_msb
        assign shr_next[gi] = sh_arith_reg & acc_reg[XLEN-1];
      end else begin : g_msb_n
        assign shr_next[gi] = acc_reg[gi+1];
      end
    end
  endgenerate

  assign shift_next = sh_left_reg ? shl_next : shr_next;

  // Control FSM, shifter state and registered writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      sh_rd_reg    <= '0;
      sh_left_reg  <= 1'b0;
      sh_arith_reg <= 1'b0;
      wb_valid_reg <= 1'b0;
      wb_we_reg    <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
      illegal_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      wb_valid_reg <= 1'b0;
      wb_we_reg    <= 1'b0;
      illegal_reg  <= 1'b0;
      if (flush_i) begin
        // Kill any in-flight shift; nothing completes on a flush edge.
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (accept) begin
              if (is_shift && (shamt != '0)) begin
                acc_reg      <= rs1_data_i;
                cnt_reg      <= shamt;
                sh_rd_reg    <= rd_i;
                sh_left_reg  <= ~funct3_i[2];
                sh_arith_reg <= funct3_i[2] & funct7_i[5];
                state_reg    <= SHIFT;
                busy_reg     <= 1'b1;
              end else begin
                wb_valid_reg <= 1'b1;
                wb_rd_reg    <= rd_i;
                wb_data_reg  <= supported ? alu_result : '0;
                wb_we_reg    <= supported & (rd_i != 5'd0);
                illegal_reg  <= ~supported;
              end
            end
          end
          SHIFT: begin
            acc_reg <= shift_next;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == SHAMT_W'(1)) begin
              wb_valid_reg <= 1'b1;
              wb_rd_reg    <= sh_rd_reg;
              wb_data_reg  <= shift_next;
              wb_we_reg    <= (sh_rd_reg != 5'd0);
              state_reg    <= IDLE;
              busy_reg     <= 1'b0;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign wb_valid_o = wb_valid_reg;
  assign wb_we_o    = wb_we_reg;
  assign wb_rd_o    = wb_rd_reg;
  assign wb_data_o  = wb_data_reg;
  assign illegal_o  = illegal_reg;
  assign busy_o     = busy_reg;

endmodule

// File: tb/tb_ex_alu_seq.sv
// Bench for ex_alu_seq: vector table of single-cycle ops, plus hand
// sequences for iterative shifts, flush and mid-shift reset. Writebacks
// are matched against a scoreboard queue filled when stimulus is driven.
module tb_ex_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [6:0]  opcode_i;
  logic [4:0]  rd_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] imm_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        illegal_o;
  logic        busy_o;

  ex_alu_seq dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .opcode_i(opcode_i), .rd_i(rd_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .imm_i(imm_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .illegal_o(illegal_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111,
                         LOAD = 7'b0000011;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp;
    logic        we;
    logic        ill;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one instruction for one edge; optionally record the expected writeback.
  task automatic drive(input vec_t v, input bit push);
    opcode_i = v.op; funct3_i = v.f3; funct7_i = v.f7; rd_i = v.rd;
    imm_i = v.imm; rs1_data_i = v.rs1; rs2_data_i = v.rs2;
    in_valid_i = 1'b1;
    if (push) sb.push_back('{rd: v.rd, data: v.exp, we: v.we, ill: v.ill});
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 64 && !in_ready_o; k++) begin
      @(posedge clk); #1;
    end
    check("ready_timeout", {63'd0, in_ready_o}, 64'd1);
  endtask

  // Scoreboard monitor: every writeback pulse must match the next expected entry.
  always @(negedge clk) begin
    if (wb_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        exp_t a;
        e = sb.pop_front();
        a = '{rd: wb_rd_o, data: wb_data_o, we: wb_we_o, ill: illegal_o};
        if (e.ill) begin
          a.rd = e.rd;
        end
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL wb actual rd=%0d data=%h we=%b ill=%b required rd=%0d data=%h we=%b ill=%b",
                   a.rd, a.data, a.we, a.ill, e.rd, e.data, e.we, e.ill);
        end
        $display("[TB] wb rd=%0d data=%h we=%b ill=%b", wb_rd_o, wb_data_o, wb_we_o, illegal_o);
      end
    end
  end

  initial begin
    vec_t v;
    int   lat;
    int   low;
    int   pulses;

    //          op   f3    f7     rd  imm           rs1           rs2           exp           we ill
    vecs[0]  = '{OP,  3'd0, 7'h00, 3,  32'h0,        32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 0};
    vecs[1]  = '{OP,  3'd0, 7'h20, 3,  32'h0,        32'h0,        32'h1,        32'hFFFFFFFF, 1, 0};
    vecs[2]  = '{OP,  3'd2, 7'h00, 6,  32'h0,        32'hFFFFFFFF, 32'h1,        32'h1,        1, 0};
    vecs[3]  = '{OP,  3'd3, 7'h00, 6,  32'h0,        32'hFFFFFFFF, 32'h1,        32'h0,        1, 0};
    vecs[4]  = '{OPI, 3'd4, 7'h7F, 7,  32'hFFFFFFFF, 32'hF0F0F0F0, 32'h0,        32'h0F0F0F0F, 1, 0};
    vecs[5]  = '{OPI, 3'd7, 7'h00, 8,  32'h0000FF00, 32'h12345678, 32'h0,        32'h00005600, 1, 0};
    vecs[6]  = '{OP,  3'd6, 7'h00, 9,  32'h0,        32'h000000F0, 32'h00000F00, 32'h00000FF0, 1, 0};
    vecs[7]  = '{OPI, 3'd0, 7'h20, 10, 32'h00000400, 32'h10,       32'h0,        32'h00000410, 1, 0};
    vecs[8]  = '{OPI, 3'd2, 7'h00, 11, 32'h0,        32'h80000000, 32'h0,        32'h1,        1, 0};
    vecs[9]  = '{OP,  3'd1, 7'h00, 12, 32'h0,        32'hDEADBEEF, 32'h20,       32'hDEADBEEF, 1, 0};
    vecs[10] = '{OPI, 3'd0, 7'h00, 0,  32'h1,        32'h1,        32'h0,        32'h2,        0, 0};
    vecs[11] = '{LOAD,3'd2, 7'h00, 5,  32'h4,        32'h100,      32'h0,        32'h0,        0, 1};
    vecs[12] = '{OPI, 3'd0, 7'h00, 1,  32'h5,        32'h0,        32'h0,        32'h5,        1, 0};
    vecs[13] = '{OPI, 3'd6, 7'h00, 2,  32'h3,        32'h0,        32'h0,        32'h3,        1, 0};
    vecs[14] = '{LUI, 3'd0, 7'h00, 4,  32'h12345000, 32'hAAAAAAAA, 32'h0,        32'h12345000, 1, 0};
    vecs[15] = '{OP,  3'd0, 7'h20, 13, 32'h0,        32'h5,        32'h7,        32'hFFFFFFFE, 1, 0};

    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0;
    opcode_i = '0; rd_i = '0; funct3_i = '0; funct7_i = '0;
    imm_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    tick(3);
    rst = 1'b0;
    check("reset_state",
          {21'd0, wb_valid_o, wb_we_o, illegal_o, busy_o, wb_rd_o, wb_data_o, in_ready_o},
          {21'd0, 4'b0000, 5'd0, 32'd0, 1'b1});

    // Back-to-back single-cycle ops: every accept pulses wb on the next cycle.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i], 1'b1);
      check($sformatf("b2b_pulse_%0d", i), {63'd0, wb_valid_o}, 64'd1);
    end
    tick(1);
    check("pulse_single_cycle", {63'd0, wb_valid_o}, 64'd0);

    // SRAI x5, shamt 31: ready low 31 cycles, wb exactly 31 cycles after accept.
    v = '{OPI, 3'd5, 7'h20, 5, 32'h0000041F, 32'h80000000, 32'h0, 32'hFFFFFFFF, 1, 0};
    drive(v, 1'b1);
    lat = -1; low = 0;
    for (int k = 0; k <= 40 && lat < 0; k++) begin
      if (wb_valid_o) lat = k;
      else if (!in_ready_o) low++;
      if (lat < 0) begin
        @(posedge clk); #1;
      end
    end
    check("srai_latency", 64'(lat), 64'd31);
    check("srai_ready_low", 64'(low), 64'd31);
    tick(1);

    // Register-amount shifts through the iterative path.
    v = '{OP, 3'd1, 7'h00, 15, 32'h0, 32'h1, 32'h3F, 32'h80000000, 1, 0};
    drive(v, 1'b1); wait_ready(); tick(1);
    v = '{OP, 3'd5, 7'h00, 16, 32'h0, 32'h80000000, 32'h4, 32'h08000000, 1, 0};
    drive(v, 1'b1); wait_ready(); tick(1);
    v = '{OP, 3'd5, 7'h20, 17, 32'h0, 32'hF0000000, 32'h4, 32'hFF000000, 1, 0};
    drive(v, 1'b1); wait_ready(); tick(1);

    // Flush with an offered instruction in IDLE: not accepted.
    flush_i = 1'b1;
    drive(vecs[0], 1'b0);
    flush_i = 1'b0;
    check("flush_idle_no_wb", {63'd0, wb_valid_o}, 64'd0);
    tick(1);

    // SRLI shamt 8 killed by flush on cycle 4; following ADD completes.
    v = '{OPI, 3'd5, 7'h00, 18, 32'h8, 32'hFF000000, 32'h0, 32'h0, 1, 0};
    drive(v, 1'b0);
    tick(3);
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
    check("flush_shift_ready", {62'd0, in_ready_o, busy_o}, 64'b10);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (wb_valid_o) pulses++;
      tick(1);
    end
    check("flush_shift_no_wb", 64'(pulses), 64'd0);
    v = '{OP, 3'd0, 7'h00, 19, 32'h0, 32'h11, 32'h22, 32'h33, 1, 0};
    drive(v, 1'b1);
    check("post_flush_add", {63'd0, wb_valid_o}, 64'd1);
    tick(1);

    // Reset mid-shift (shamt 20, cycle 10): outputs clear, no writeback ever.
    v = '{OPI, 3'd1, 7'h00, 20, 32'd20, 32'h1, 32'h0, 32'h0, 1, 0};
    drive(v, 1'b0);
    tick(9);
    check("shift_busy_before_rst", {63'd0, busy_o}, 64'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_shift",
          {21'd0, wb_valid_o, wb_we_o, illegal_o, busy_o, wb_rd_o, wb_data_o, in_ready_o},
          {21'd0, 4'b0000, 5'd0, 32'd0, 1'b1});
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      if (wb_valid_o) pulses++;
      tick(1);
    end
    check("rst_shift_no_wb", 64'(pulses), 64'd0);

    tick(2);
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
